bit_stream_feeder: RTL and testbench
====================================

// Module: bit_stream_feeder
// PURPOSE
//   Parallel-in, serial-out stage sitting directly upstream of the moore 1101
//   sequence detector. Accepts a NUM_BITS word via valid/ready handshake and
//   drives it MSB-first, one bit per enabled clock, onto serial_out (-> moore.i).
//   Signals end of each word so the test harness/sequencer can chain words.
// PARAMETERS
//   NUM_BITS   8     word width / bits per stream burst (>= 2)
//   IDLE_BIT   1'b0  value driven on serial_out when no word is in flight
// PORTS
//   clk         in   1         system clock, all state on rising edge
//   n_rst       in   1         async active-low reset
//   load_data   in   NUM_BITS  word to stream, sampled on handshake edge only
//   load_valid  in   1         load_data valid
//   load_ready  out  1         feeder can accept a word this cycle
//   shift_en    in   1         1 = advance one bit per clock; 0 = stall/hold
//   serial_out  out  1         registered serial bit stream, MSB first
//   busy        out  1         word in flight (state SHIFT)
//   word_done   out  1         1-cycle pulse coincident with last bit of word
// BEHAVIOUR
//   - Reset (async, n_rst=0): state=IDLE, shift reg=IDLE_BIT fill, bit_cnt=0,
//     serial_out=IDLE_BIT, busy=0, word_done=0, load_ready=1. Reset mid-word
//     aborts word immediately; no word_done.
//   - All outputs registered except load_ready (comb. from state/bit_cnt/shift_en).
//   - States: IDLE, SHIFT.
//   - IDLE: load_ready=1. Handshake = load_valid&load_ready at rising edge k
//     -> capture load_data, bit_cnt=0, go SHIFT. shift_en not required to load.
//   - SHIFT: serial_out = current MSB of shift reg. Bit i of word (i=0 is MSB)
//     presented in cycle after edge k+i when shift_en held 1 (latency 1 clk).
//     On edge with shift_en=1: shift left, fill IDLE_BIT, bit_cnt++.
//     shift_en=0: shift reg, bit_cnt, serial_out, word_done all hold.
//   - word_done=1 exactly in the cycle the last bit (LSB) is on serial_out;
//     clears on next enabled edge; held high while stalled on last bit.
//   - Last bit + enabled edge, no new handshake: -> IDLE, serial_out=IDLE_BIT.
//   - load_ready=0 throughout SHIFT (base build); load_valid then ignored,
//     load_data need not be held, no error raised.
//   - bit_cnt width $clog2(NUM_BITS); never exceeds NUM_BITS-1, no wrap.
//   - load_valid high continuously in IDLE: one word per accept, 1 IDLE_BIT
//     gap cycle between words (base build).
// CONFIGURATION
//   BACK_TO_BACK_EN defined: load_ready also 1 during last-bit cycle when
//     shift_en=1; handshake on that edge loads new word, stays SHIFT, new MSB
//     follows old LSB with no IDLE_BIT gap; word_done pulses per word.
//   BACK_TO_BACK_EN undefined: load_ready only in IDLE; min 1 gap cycle.
// TESTING
//   1 Reset: n_rst=0 mid-sim -> serial_out=IDLE_BIT, busy=0, word_done=0,
//     load_ready=1 without waiting for clk; held across a clock in reset.
//   2 Single word: load 8'b1101_0000, shift_en=1 -> serial_out 1,1,0,1,0,0,0,0
//     on 8 consecutive cycles, word_done only on 8th, then IDLE_BIT; chained
//     moore.o=1 one cycle after 4th bit.
//   3 Stall: load 8'hA5, shift_en=0 for 3 cycles after bit 2 -> bit 2 held
//     3 extra cycles, full stream 1,0,1,0,0,1,0,1 otherwise intact.
//   4 Busy ignore: load 8'hFF then pulse load_valid with 8'h00 at bit 4 ->
//     load_ready=0, stream stays eight 1s, second word never emitted.
//   5 Back-to-back (BACK_TO_BACK_EN): load_valid held, 8'hD0 then 8'h0D ->
//     16 contiguous bits 11010000_00001101, two word_done pulses at cycles 8,16;
//     base build: one IDLE_BIT gap cycle between the words.
//   6 Reset mid-word: n_rst=0 during bit 3 of 8'hFF -> serial_out=IDLE_BIT,
//     no word_done; after release next load starts from its MSB.

Source files
------------

// File: rtl/bit_stream_feeder.sv
// -----------------------------------------------------------------------------
// bit_stream_feeder
//
// Parallel-in, serial-out stage feeding a serial sequence detector. A
// NUM_BITS-wide word is accepted on a valid/ready handshake and streamed
// MSB-first onto serial_out, one bit per clock while shift_en is high. When
// shift_en is low, the stream stalls. word_done marks the cycle in which the
// last bit (the LSB) is on serial_out.
//
// Parameters
//   NUM_BITS   word width / bits per burst (>= 2)
//   IDLE_BIT   level driven on serial_out when no word is in flight
//
// Optional feature (compile-time macro BACK_TO_BACK_EN)
//   When BACK_TO_BACK_EN is defined, load_ready is also raised during the
//   last-bit cycle of a word (when shift_en is high). A word accepted on that
//   edge follows the previous LSB with no idle gap.
//   When the macro is undefined, words are accepted only in IDLE. This leaves
//   at least one IDLE_BIT cycle between consecutive words.
//
// Ports
//   clk         in   system clock, rising edge
//   n_rst       in   asynchronous active-low reset
//   load_data   in   word to stream, sampled only on the handshake edge
//   load_valid  in   load_data is valid
//   load_ready  out  feeder can accept a word this cycle (combinational)
//   shift_en    in   1 = advance one bit per clock, 0 = hold
//   serial_out  out  registered serial bit, MSB first
//   busy        out  a word is in flight
//   word_done   out  high while the last bit of a word is on serial_out
// -----------------------------------------------------------------------------
module bit_stream_feeder #(
    parameter int   NUM_BITS = 8,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic [NUM_BITS-1:0] load_data,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic                shift_en,
    output logic                serial_out,
    output logic                busy,
    output logic                word_done
);

    localparam int CNT_W = (NUM_BITS > 2) ? $clog2(NUM_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BITS - 1);
    localparam logic [CNT_W-1:0] PENULT_IDX = CNT_W'(NUM_BITS - 2);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t                state, state_nx;
    logic [NUM_BITS-1:0]   shift_reg, shift_nx;
    logic [CNT_W-1:0]      bit_cnt, cnt_nx;
    logic                  serial_nx;
    logic                  busy_nx;
    logic                  done_nx;
    logic                  handshake;
    logic                  on_last_bit;

    assign on_last_bit = (state == SHIFT) && (bit_cnt == LAST_IDX);

    // load_ready is the only combinational output.
    always_comb begin
        load_ready = (state == IDLE);
`ifdef BACK_TO_BACK_EN
        if (on_last_bit && shift_en)
            load_ready = 1'b1;
`endif
    end

    assign handshake = load_valid && load_ready;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            shift_reg  <= {NUM_BITS{IDLE_BIT}};
            bit_cnt    <= '0;
            serial_out <= IDLE_BIT;
            busy       <= 1'b0;
            word_done  <= 1'b0;
        end else begin
            state      <= state_nx;
            shift_reg  <= shift_nx;
            bit_cnt    <= cnt_nx;
            serial_out <= serial_nx;
            busy       <= busy_nx;
            word_done  <= done_nx;
        end
    end

    // The shift register keeps the bit on serial_out in its MSB. A shift
    // therefore exposes shift_reg[NUM_BITS-2] as the next serial bit.
    always_comb begin
        state_nx  = state;
        shift_nx  = shift_reg;
        cnt_nx    = bit_cnt;
        serial_nx = serial_out;
        busy_nx   = busy;
        done_nx   = word_done;

        case (state)
            IDLE: begin
                // Loading does not depend on shift_en.
                if (handshake) begin
                    state_nx  = SHIFT;
                    shift_nx  = load_data;
                    cnt_nx    = '0;
                    serial_nx = load_data[NUM_BITS-1];
                    busy_nx   = 1'b1;
                    done_nx   = 1'b0;
                end
            end

            SHIFT: begin
                if (shift_en) begin
                    if (on_last_bit) begin
                        if (handshake) begin
                            // Back-to-back: the new MSB directly follows the old LSB.
                            state_nx  = SHIFT;
                            shift_nx  = load_data;
                            cnt_nx    = '0;
                            serial_nx = load_data[NUM_BITS-1];
                            busy_nx   = 1'b1;
                            done_nx   = 1'b0;
                        end else begin
                            state_nx  = IDLE;
                            shift_nx  = {NUM_BITS{IDLE_BIT}};
                            cnt_nx    = '0;
                            serial_nx = IDLE_BIT;
                            busy_nx   = 1'b0;
                            done_nx   = 1'b0;
                        end
                    end else begin
                        shift_nx  = {shift_reg[NUM_BITS-2:0], IDLE_BIT};
                        cnt_nx    = bit_cnt + CNT_W'(1);
                        serial_nx = shift_reg[NUM_BITS-2];
                        // Raise word_done as the LSB moves onto serial_out.
                        done_nx   = (bit_cnt == PENULT_IDX);
                    end
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bit_stream_feeder.sv
module tb_bit_stream_feeder;

    localparam int   NB   = 8;
    localparam logic IDLE = 1'b0;

    logic          tb_clk;
    logic          n_rst;
    logic [NB-1:0] load_data;
    logic          load_valid;
    logic          load_ready;
    logic          shift_en;
    logic          serial_out;
    logic          busy;
    logic          word_done;

    int n_tests;
    int n_fail;

    bit_stream_feeder #(.NUM_BITS(NB), .IDLE_BIT(IDLE)) dut (
        .clk        (tb_clk),
        .n_rst      (n_rst),
        .load_data  (load_data),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .shift_en   (shift_en),
        .serial_out (serial_out),
        .busy       (busy),
        .word_done  (word_done)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        #1;
        n_tests++;
        if (serial_out !== IDLE || busy !== 1'b0 || word_done !== 1'b0 || load_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_initial: ser=%b busy=%b done=%b rdy=%b expected ser=%b busy=0 done=0 rdy=1",
                     serial_out, busy, word_done, load_ready, IDLE);
        end
        step();
        n_rst = 1'b1;
        step();

        // Assert reset mid-word, away from any clock edge.
        load_data = 8'hFF; load_valid = 1'b1; shift_en = 1'b1;
        step();
        load_valid = 1'b0;
        step();
        #2 n_rst = 1'b0;
        #1;
        n_tests++;
        if (serial_out !== IDLE || busy !== 1'b0 || word_done !== 1'b0 || load_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_async: ser=%b busy=%b done=%b rdy=%b expected ser=%b busy=0 done=0 rdy=1",
                     serial_out, busy, word_done, load_ready, IDLE);
        end
        step();
        n_tests++;
        if (serial_out !== IDLE || busy !== 1'b0 || word_done !== 1'b0 || load_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_held: ser=%b busy=%b done=%b rdy=%b expected ser=%b busy=0 done=0 rdy=1",
                     serial_out, busy, word_done, load_ready, IDLE);
        end
        n_rst = 1'b1;
        step();
        n_tests++;
        if (busy !== 1'b0 || serial_out !== IDLE) begin
            n_fail++;
            $display("FAIL reset_release: busy=%b ser=%b expected busy=0 ser=%b", busy, serial_out, IDLE);
        end
    endtask

    task automatic test_single_word();
        logic [NB-1:0] w;
        w = 8'b1101_0000;
        load_data = w; load_valid = 1'b1; shift_en = 1'b1;
        n_tests++;
        if (load_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ready_idle: got %b expected 1", load_ready);
        end
        step();
        load_valid = 1'b0;
        load_data  = 8'h00;
        for (int i = 0; i < NB; i++) begin
            n_tests++;
            if (serial_out !== w[NB-1-i] || word_done !== (i == NB-1) || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL single_bit%0d: ser=%b done=%b busy=%b expected ser=%b done=%b busy=1",
                         i, serial_out, word_done, busy, w[NB-1-i], (i == NB-1));
            end
            if (i == 0) begin
                n_tests++;
                if (load_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL single_ready_busy: got %b expected 0", load_ready);
                end
            end
            step();
        end
        n_tests++;
        if (serial_out !== IDLE || busy !== 1'b0 || word_done !== 1'b0) begin
            n_fail++;
            $display("FAIL single_end: ser=%b busy=%b done=%b expected ser=%b busy=0 done=0",
                     serial_out, busy, word_done, IDLE);
        end
    endtask

    task automatic test_stall();
        logic [NB-1:0] w;
        w = 8'hA5;
        load_data = w; load_valid = 1'b1; shift_en = 1'b1;
        step();
        load_valid = 1'b0;
        for (int i = 0; i < NB; i++) begin
            n_tests++;
            if (serial_out !== w[NB-1-i] || word_done !== (i == NB-1)) begin
                n_fail++;
                $display("FAIL stall_bit%0d: ser=%b done=%b expected ser=%b done=%b",
                         i, serial_out, word_done, w[NB-1-i], (i == NB-1));
            end
            if (i == 2) begin
                shift_en = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    step();
                    n_tests++;
                    if (serial_out !== w[NB-1-i] || word_done !== 1'b0 || busy !== 1'b1) begin
                        n_fail++;
                        $display("FAIL stall_hold%0d: ser=%b done=%b busy=%b expected ser=%b done=0 busy=1",
                                 s, serial_out, word_done, busy, w[NB-1-i]);
                    end
                end
                shift_en = 1'b1;
            end
            step();
        end
        n_tests++;
        if (serial_out !== IDLE || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_end: ser=%b busy=%b expected ser=%b busy=0", serial_out, busy, IDLE);
        end

        // Stall on the last bit: word_done stays high.
        load_data = 8'h01; load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        for (int i = 0; i < NB - 1; i++) step();
        shift_en = 1'b0;
        step();
        step();
        n_tests++;
        if (serial_out !== 1'b1 || word_done !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_last: ser=%b done=%b busy=%b expected ser=1 done=1 busy=1",
                     serial_out, word_done, busy);
        end
        shift_en = 1'b1;
        step();
        n_tests++;
        if (serial_out !== IDLE || word_done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_last_release: ser=%b done=%b busy=%b expected ser=%b done=0 busy=0",
                     serial_out, word_done, busy, IDLE);
        end
    endtask

    task automatic test_busy_ignore();
        load_data = 8'hFF; load_valid = 1'b1; shift_en = 1'b1;
        step();
        load_valid = 1'b0;
        for (int i = 0; i < NB; i++) begin
            n_tests++;
            if (serial_out !== 1'b1) begin
                n_fail++;
                $display("FAIL busy_bit%0d: ser=%b expected 1", i, serial_out);
            end
            if (i == 4) begin
                load_data = 8'h00; load_valid = 1'b1;
                #1;
                n_tests++;
                if (load_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL busy_ready: got %b expected 0", load_ready);
                end
            end
            step();
            load_valid = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (serial_out !== IDLE || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL busy_no_second%0d: ser=%b busy=%b expected ser=%b busy=0",
                         i, serial_out, busy, IDLE);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [2*NB-1:0] w;
        w = 16'hD00D;
        load_data = 8'hD0; load_valid = 1'b1; shift_en = 1'b1;
        step();
        load_data = 8'h0D;
`ifdef BACK_TO_BACK_EN
        for (int i = 0; i < 2*NB; i++) begin
            n_tests++;
            if (serial_out !== w[2*NB-1-i] || word_done !== (i == NB-1 || i == 2*NB-1)) begin
                n_fail++;
                $display("FAIL b2b_bit%0d: ser=%b done=%b expected ser=%b done=%b",
                         i, serial_out, word_done, w[2*NB-1-i], (i == NB-1 || i == 2*NB-1));
            end
            if (i == NB-1) begin
                n_tests++;
                if (load_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_ready_last: got %b expected 1", load_ready);
                end
            end
            step();
            if (i == NB-1) load_valid = 1'b0;
        end
`else
        for (int i = 0; i < NB; i++) begin
            n_tests++;
            if (serial_out !== w[2*NB-1-i] || word_done !== (i == NB-1)) begin
                n_fail++;
                $display("FAIL b2b_w0_bit%0d: ser=%b done=%b expected ser=%b done=%b",
                         i, serial_out, word_done, w[2*NB-1-i], (i == NB-1));
            end
            step();
        end
        n_tests++;
        if (serial_out !== IDLE || busy !== 1'b0 || load_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_gap: ser=%b busy=%b rdy=%b expected ser=%b busy=0 rdy=1",
                     serial_out, busy, load_ready, IDLE);
        end
        step();
        load_valid = 1'b0;
        for (int i = NB; i < 2*NB; i++) begin
            n_tests++;
            if (serial_out !== w[2*NB-1-i] || word_done !== (i == 2*NB-1)) begin
                n_fail++;
                $display("FAIL b2b_w1_bit%0d: ser=%b done=%b expected ser=%b done=%b",
                         i, serial_out, word_done, w[2*NB-1-i], (i == 2*NB-1));
            end
            step();
        end
`endif
        n_tests++;
        if (serial_out !== IDLE || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end: ser=%b busy=%b expected ser=%b busy=0", serial_out, busy, IDLE);
        end
    endtask

    task automatic test_reset_mid_word();
        logic [NB-1:0] w;
        load_data = 8'hFF; load_valid = 1'b1; shift_en = 1'b1;
        step();
        load_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        n_tests++;
        if (serial_out !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rmw_pre: ser=%b busy=%b expected ser=1 busy=1", serial_out, busy);
        end
        #2 n_rst = 1'b0;
        #1;
        n_tests++;
        if (serial_out !== IDLE || busy !== 1'b0 || word_done !== 1'b0 || load_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rmw_async: ser=%b busy=%b done=%b rdy=%b expected ser=%b busy=0 done=0 rdy=1",
                     serial_out, busy, word_done, load_ready, IDLE);
        end
        step();
        n_rst = 1'b1;
        step();
        n_tests++;
        if (word_done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rmw_no_done: done=%b busy=%b expected done=0 busy=0", word_done, busy);
        end
        w = 8'hB3;
        load_data = w; load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        for (int i = 0; i < NB; i++) begin
            n_tests++;
            if (serial_out !== w[NB-1-i] || word_done !== (i == NB-1)) begin
                n_fail++;
                $display("FAIL rmw_bit%0d: ser=%b done=%b expected ser=%b done=%b",
                         i, serial_out, word_done, w[NB-1-i], (i == NB-1));
            end
            step();
        end
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        n_rst      = 1'b0;
        load_data  = '0;
        load_valid = 1'b0;
        shift_en   = 1'b1;

        test_reset();
        test_single_word();
        test_stall();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_word();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion before 100000");
        $fatal(1);
    end

endmodule
